// File: rtl/axi_rw_arb_pkg.sv
// Shared types and constants for the two-port axi_rw arbiter.
// Included by the round-robin sub-block and the arbiter top.
package axi_rw_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef logic port_idx_t;

    localparam int unsigned DEFAULT_TIMEOUT = 4096;

    // axi_rw treats a zero-length burst as illegal, so it is sent as one beat.
    function automatic logic [7:0] fwd_len(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: combinational winner, registered last grant.
// On a tie, the port that was not granted last wins.
import axi_rw_arb_pkg::*;

module rr_arb2 (
    input  logic      clock,
    input  logic      reset,
    input  logic [1:0] req,
    input  logic      update,
    input  port_idx_t update_idx,
    output logic      any_req,
    output port_idx_t winner
);

    port_idx_t last_grant_q;
    port_idx_t last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (update) begin
            last_grant_d = update_idx;
        end
    end

    // Reset to port 1 so that port 0 takes the very first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        any_req = |req;
        winner  = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_grant_q;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/axi_rw_arbiter.sv
// Shares one axi_rw master between the fetch port (0) and data port (1),
// one transaction at a time, with beat routing and a BUSY timeout.
//
// state | meaning
// IDLE  | no transaction; grant a requester when axi_rw is ready
// ISSUE | rw_valid pulsed for one cycle with the registered request
// BUSY  | data phase; wait for rw_ready or the timeout
// DONE  | one-cycle done (and err on timeout) to the owner
import axi_rw_arb_pkg::*;

module axi_rw_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  p0_valid,
    input  logic                  p0_write,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [7:0]            p0_strb,
    input  logic [7:0]            p0_len,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic                  p0_rvalid,
    output logic                  p0_wren,
    output logic                  p0_done,
    output logic                  p0_err,

    input  logic                  p1_valid,
    input  logic                  p1_write,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [7:0]            p1_strb,
    input  logic [7:0]            p1_len,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p1_rvalid,
    output logic                  p1_wren,
    output logic                  p1_done,
    output logic                  p1_err,

    output logic                  rw_valid,
    input  logic                  rw_ready,
    output logic                  rw_read_req,
    output logic                  rw_write_req,
    output logic [ADDR_WIDTH-1:0] rw_addr,
    output logic [7:0]            rw_size,
    output logic [7:0]            rw_len,
    output logic [DATA_WIDTH-1:0] rw_wdata,
    input  logic [DATA_WIDTH-1:0] rw_rdata,
    input  logic                  rw_rfifo_wen,
    input  logic                  rw_wfifo_ren
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_e            state_q, state_d;
    port_idx_t             grant_q, grant_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            strb_q, strb_d;
    logic [7:0]            len_q, len_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic                  any_req;
    port_idx_t             winner;
    logic                  arb_update;

    rr_arb2 u_rr_arb2 (
        .clock      (clock),
        .reset      (reset),
        .req        ({p1_valid, p0_valid}),
        .update     (arb_update),
        .update_idx (grant_q),
        .any_req    (any_req),
        .winner     (winner)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        write_d    = write_q;
        addr_d     = addr_q;
        strb_d     = strb_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        arb_update = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req && rw_ready) begin
                    state_d = ST_ISSUE;
                    grant_d = winner;
                    write_d = winner ? p1_write : p0_write;
                    addr_d  = winner ? p1_addr  : p0_addr;
                    strb_d  = winner ? p1_strb  : p0_strb;
                    len_d   = fwd_len(winner ? p1_len : p0_len);
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                // A completion landing on the last allowed cycle is not an error.
                if (rw_ready) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                arb_update = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            strb_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    logic owned;
    logic own0;
    logic own1;
    logic in_done;

    always_comb begin
        owned   = (state_q != ST_IDLE);
        own0    = owned && (grant_q == 1'b0);
        own1    = owned && (grant_q == 1'b1);
        in_done = (state_q == ST_DONE);

        rw_valid     = (state_q == ST_ISSUE);
        rw_read_req  = (state_q == ST_ISSUE) && !write_q;
        rw_write_req = (state_q == ST_ISSUE) && write_q;
        rw_addr      = addr_q;
        rw_size      = strb_q;
        rw_len       = len_q;
        rw_wdata     = '0;
        if (owned) begin
            rw_wdata = grant_q ? p1_wdata : p0_wdata;
        end

        p0_rdata  = rw_rdata;
        p1_rdata  = rw_rdata;
        p0_rvalid = rw_rfifo_wen && own0;
        p1_rvalid = rw_rfifo_wen && own1;
        p0_wren   = rw_wfifo_ren && own0;
        p1_wren   = rw_wfifo_ren && own1;
        p0_done   = in_done && own0;
        p1_done   = in_done && own1;
        p0_err    = in_done && own0 && err_q;
        p1_err    = in_done && own1 && err_q;
    end

endmodule

// File: doc/axi_rw_arbiter.md
# axi_rw_arbiter

Two-port arbiter that shares the single `axi_rw` AXI master between the instruction fetch port (port 0) and the data/memory port (port 1). It sequences one transaction at a time on the `axi_rw` request interface, routes read beats, write-FIFO pops and completion back to the owning port, and bounds each transaction with a timeout. It sits between the IF/MEM caches and `axi_rw`.

## Interface
- `DATA_WIDTH`, 64, data beat width.
- `ADDR_WIDTH`, 64, address width.
- `TIMEOUT`, 4096, maximum BUSY cycles before abort (minimum 2).
- `clock  in  1  sole clock; all state updates on rising edge.`
- `reset  in  1  asynchronous, active-low reset; 0 = reset.`
- `p{0,1}_valid  in  1  port n requests a transaction; held until p{n}_done.`
- `p{0,1}_write  in  1  1 = write, 0 = read; stable while valid.`
- `p{0,1}_addr  in  ADDR_WIDTH  start address; stable while valid.`
- `p{0,1}_strb  in  8  write strobe; forwarded to rw_size.`
- `p{0,1}_len  in  8  burst beats.`
- `p{0,1}_wdata  in  DATA_WIDTH  head of port n write FIFO.`
- `p{0,1}_rdata  out  DATA_WIDTH  read beat, valid when p{n}_rvalid.`
- `p{0,1}_rvalid  out  1  read beat strobe (gated rfifo_wen).`
- `p{0,1}_wren  out  1  pop port n write FIFO (gated wfifo_ren).`
- `p{0,1}_done  out  1  one-cycle completion pulse.`
- `p{0,1}_err  out  1  one-cycle timeout pulse, coincident with done.`
- `rw_valid  out  1  to axi_rw rw_valid_i.`
- `rw_ready  in  1  from axi_rw rw_ready_o.`
- `rw_read_req`, `rw_write_req  out  1  to axi_rw read_req/write_req.`
- `rw_addr  out  ADDR_WIDTH`, `rw_size  out  8`, `rw_len  out  8`, `rw_wdata  out  DATA_WIDTH`: to axi_rw.
- `rw_rdata  in  DATA_WIDTH`, `rw_rfifo_wen  in  1`, `rw_wfifo_ren  in  1`: from axi_rw.

## Operation
- FSM states: IDLE, ISSUE, BUSY, DONE.
- IDLE: if any `p_valid` and `rw_ready`=1, grant the winner, go ISSUE. Otherwise stay.
- Round-robin: with one requester, it wins. With both, the port not granted last wins. `last_grant` resets to 1, so port 0 wins the first tie.
- ISSUE: drive `rw_valid`=1 for exactly this cycle, with `rw_read_req`=~write and `rw_write_req`=write of the grantee. Go BUSY.
- BUSY: stay until `rw_ready`=1, then go DONE. Timeout counter increments each BUSY cycle. At `TIMEOUT`, go DONE with the error flag set.
- DONE: pulse the grantee's `p_done` (and `p_err` if timed out), update `last_grant`, go IDLE. That port must drop or replace `valid` next cycle; a new grant occurs no earlier than the IDLE cycle.
- Request fields `addr`/`strb`/`len`/`write` are registered at grant. `rw_wdata` is a combinational mux of the grantee's `wdata`.
- `len`=0 is forwarded as 1.
- Routing: `p_rvalid`/`p_wren` = `rw_rfifo_wen`/`rw_wfifo_ren` AND (grant==n AND state∈{ISSUE,BUSY,DONE}). Non-owner outputs are 0. `p_rdata` = `rw_rdata` for both ports.
- Reset mid-transaction: return to IDLE, all outputs 0, counter 0, `last_grant`=1. The downstream `axi_rw` is reset by the same event.

## Timing
- Reset values: all outputs 0, `rw_addr`/`rw_len`/`rw_size` 0.
- Minimum valid→rw_valid latency: 1 cycle (valid seen in IDLE, rw_valid in ISSUE).
- `p_done` arrives 1 cycle after `rw_ready` returns high.
- Back-to-back: IDLE→ISSUE→BUSY≥1→DONE→IDLE, so at least 4 cycles per transaction.
- `p_valid` deasserting before done is illegal; the behaviour is undefined, but the FSM still completes.
- Simultaneous valid in IDLE with `rw_ready`=0: no grant; re-evaluate next cycle.

## Structure
- Package `axi_rw_arb_pkg`: state enum `arb_state_e`, port-index typedef, `DEFAULT_TIMEOUT`.
- Sub-module `rr_arb2` (combinational winner + registered `last_grant`). Everything else stays flat.

## Test plan
- Single read: p0 read addr 0x8000_0000, len 4. Expected: `rw_valid` one cycle, `rw_len`=4, four `p0_rvalid` beats, p1 outputs 0, one `p0_done`.
- Tie: p0 and p1 both valid from reset. Expected: p0 granted first, then p1, then p0 again if it re-requests.
- Write routing: p1 write len 2, strb 0xFF. Expected: `rw_write_req`=1, `rw_size`=0xFF, two `p1_wren` pulses, `p1_done`; `p0_wren` stays 0.
- len=0: p0 read with len 0. Expected: `rw_len`=1, one beat.
- Timeout: `TIMEOUT`=8 with `rw_ready` stuck low after issue. Expected: `p_done` and `p_err` after 8 BUSY cycles, then back to IDLE.
- Reset mid-BUSY: assert `reset`=0 asynchronously. Expected: outputs 0 immediately; first grant after release goes to p0.
